// File: rtl/shift_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_sequencer_if
// Brief   : Command handshake, register drive and result bundle for the
//           shift-register sequencer.
// Revision: 1.0  initial release
// ============================================================================
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_count;
    logic             enb;
    logic             dir;
    logic             s_in;
    logic [1:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             s_out;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] sout_bits;
    logic             done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count, q, s_out,
        output cmd_ready, enb, dir, s_in, modo, d, result, sout_bits, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_data, cmd_count, q, s_out,
        input  cmd_ready, enb, dir, s_in, modo, d, result, sout_bits, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_sequencer
// Brief   : Turns one host command into the ENB/DIR/S_IN/MODO/D cycle sequence
//           for a 4-bit shift register and returns Q / serial-out with DONE.
// Revision: 1.0  initial release
// ============================================================================
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_reg_sequencer_if.slave  bus
);

    localparam logic [1:0] c_op_serial   = 2'b00;
    localparam logic [1:0] c_op_load_rot = 2'b11;
    localparam logic [1:0] c_modo_serial = 2'b00;
    localparam logic [1:0] c_modo_circ   = 2'b01;
    localparam logic [1:0] c_modo_load   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state,   w_state;
    logic             r_ready,   w_ready;
    logic             r_done,    w_done;
    logic             r_enb,     w_enb;
    logic             r_dir,     w_dir;
    logic             r_s_in,    w_s_in;
    logic [1:0]       r_modo,    w_modo;
    logic [WIDTH-1:0] r_d,       w_d;
    logic [WIDTH-1:0] r_result,  w_result;
    logic [WIDTH-1:0] r_sout,    w_sout;
    logic [1:0]       r_op,      w_op;
    logic             r_cmd_dir, w_cmd_dir;
    logic [CNT_W-1:0] r_cnt,     w_cnt;
    logic [WIDTH-1:0] r_pay,     w_pay;
    logic [CNT_W-1:0] r_k,       w_k;

    // Every output is a flop loaded with its next-cycle value, so the register
    // sees the control word for a LOAD/SHIFT cycle throughout that cycle.
    always_comb begin
        w_state   = r_state;
        w_ready   = 1'b0;
        w_done    = 1'b0;
        w_enb     = 1'b0;
        w_dir     = r_dir;
        w_s_in    = r_s_in;
        w_modo    = r_modo;
        w_d       = r_d;
        w_result  = r_result;
        w_sout    = r_sout;
        w_op      = r_op;
        w_cmd_dir = r_cmd_dir;
        w_cnt     = r_cnt;
        w_pay     = r_pay;
        w_k       = r_k;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.cmd_valid) begin
                    w_op      = bus.cmd_op;
                    w_cmd_dir = bus.cmd_dir;
                    w_cnt     = bus.cmd_count;
                    w_pay     = bus.cmd_data;
                    w_k       = '0;
                    if (bus.cmd_op == c_op_serial)
                        w_sout = '0;
                    if (bus.cmd_op[1]) begin
                        w_state = S_LOAD;
                        w_enb   = 1'b1;
                        w_modo  = c_modo_load;
                        w_d     = bus.cmd_data;
                    end else if (bus.cmd_count != '0) begin
                        w_state = S_SHIFT;
                        w_enb   = 1'b1;
                        w_dir   = bus.cmd_dir;
                        if (bus.cmd_op == c_op_serial) begin
                            w_modo = c_modo_serial;
                            w_s_in = bus.cmd_data[0];
                            w_pay  = bus.cmd_data >> 1;
                        end else begin
                            w_modo = c_modo_circ;
                        end
                    end else begin
                        w_state = S_CAPTURE;
                    end
                end else begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                end
            end

            S_LOAD: begin
                if (r_op == c_op_load_rot && r_cnt != '0) begin
                    w_state = S_SHIFT;
                    w_enb   = 1'b1;
                    w_dir   = r_cmd_dir;
                    w_modo  = c_modo_circ;
                end else begin
                    w_state = S_CAPTURE;
                end
            end

            S_SHIFT: begin
                w_k   = r_k + 1'b1;
                w_cnt = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                if (r_op == c_op_serial) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_k == CNT_W'(i))
                            w_sout[i] = bus.s_out;
                    end
                end
                if (r_cnt > CNT_W'(1)) begin
                    w_enb = 1'b1;
                    // Payload drains LSB first; zeros follow once it is empty.
                    if (r_op == c_op_serial) begin
                        w_s_in = r_pay[0];
                        w_pay  = r_pay >> 1;
                    end
                end else begin
                    w_state = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                w_result = bus.q;
                w_state  = S_DONE;
                w_done   = 1'b1;
                w_ready  = 1'b1;
            end

            default: begin
                w_state = S_IDLE;
                w_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_enb     <= 1'b0;
            r_dir     <= 1'b0;
            r_s_in    <= 1'b0;
            r_modo    <= 2'b00;
            r_d       <= '0;
            r_result  <= '0;
            r_sout    <= '0;
            r_op      <= 2'b00;
            r_cmd_dir <= 1'b0;
            r_cnt     <= '0;
            r_pay     <= '0;
            r_k       <= '0;
        end else begin
            r_state   <= w_state;
            r_ready   <= w_ready;
            r_done    <= w_done;
            r_enb     <= w_enb;
            r_dir     <= w_dir;
            r_s_in    <= w_s_in;
            r_modo    <= w_modo;
            r_d       <= w_d;
            r_result  <= w_result;
            r_sout    <= w_sout;
            r_op      <= w_op;
            r_cmd_dir <= w_cmd_dir;
            r_cnt     <= w_cnt;
            r_pay     <= w_pay;
            r_k       <= w_k;
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.done      = r_done;
    assign bus.enb       = r_enb;
    assign bus.dir       = r_dir;
    assign bus.s_in      = r_s_in;
    assign bus.modo      = r_modo;
    assign bus.d         = r_d;
    assign bus.result    = r_result;
    assign bus.sout_bits = r_sout;

endmodule
`default_nettype wire
